// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_fs1.sv
// Purely combinational 1-bit full subtractor: d = a - b - bin, bout = borrow.
module fs1 (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (Diff = A - B - Bin), LSB first, one bit per clock,
// with a start/busy/done handshake and registered outputs.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh, b_sh, d_sh, d_sh_nx;
    logic             br, d_bit, br_nx;
    logic             accept, last;

    fs1 u_fs1 (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_nx)
    );

    // Each new difference bit enters at the MSB so the first bit ends at the LSB.
    assign d_sh_nx = {d_bit, d_sh[WIDTH-1:1]};

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SHIFT;
                    accept   = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    state_nx = DONE;
                    last     = 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            Diff  <= '0;
            Bout  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            d_sh  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == SHIFT);
            done  <= last;
            if (accept) begin
                a_sh <= A;
                b_sh <= B;
                br   <= Bin;
                d_sh <= '0;
                cnt  <= '0;
            end else if (state == SHIFT) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                br   <= br_nx;
                d_sh <= d_sh_nx;
                cnt  <= cnt + CW'(1);
            end
            // Result registers only move on the completing edge.
            if (last) begin
                Diff <= d_sh_nx;
                Bout <= br_nx;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor (WIDTH=4).
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic       Bin = 1'b0;
    logic       busy, done, Bout;
    logic [3:0] Diff;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] diff;
        logic       bout;
    } vec_t;

    vec_t vecs [9];

    serial_subtractor #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
        .Bout  (Bout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation from IDLE; returns result, latency and busy-cycle count.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                          input bit scramble, output logic [3:0] d, output logic bo,
                          output int lat, output int bcnt);
        @(negedge clk);
        A = a; B = b; Bin = bin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (scramble) begin
            A = 4'b1111; B = 4'b0000; Bin = 1'b1;
        end
        lat  = -1;
        bcnt = busy ? 1 : 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) bcnt++;
        end
        d  = Diff;
        bo = Bout;
        chk("busy_low_at_done", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", {31'b0, done}, 32'd0);
    endtask

    initial begin
        logic [3:0] d;
        logic       bo;
        int         lat, bcnt;
        int         prev, ndone;
        bit         stable_ok, no_done;
        logic [4:0] full;

        vecs[0] = '{4'b0110, 4'b0100, 1'b0, 4'b0010, 1'b0};
        vecs[1] = '{4'b1000, 4'b1001, 1'b1, 4'b1110, 1'b1};
        vecs[2] = '{4'b1110, 4'b0010, 1'b0, 4'b1100, 1'b0};
        vecs[3] = '{4'b1010, 4'b1011, 1'b0, 4'b1111, 1'b1};
        vecs[4] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1};
        vecs[5] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1};
        vecs[6] = '{4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0};
        vecs[7] = '{4'b0000, 4'b1111, 1'b0, 4'b0001, 1'b1};
        vecs[8] = '{4'b0101, 4'b0011, 1'b1, 4'b0001, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_diff", {28'b0, Diff}, 32'd0);
        chk("reset_bout", {31'b0, Bout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int v = 0; v < 9; v++) begin
            run_op(vecs[v].a, vecs[v].b, vecs[v].bin, 1'b0, d, bo, lat, bcnt);
            chk($sformatf("vec%0d_diff", v), {28'b0, d}, {28'b0, vecs[v].diff});
            chk($sformatf("vec%0d_bout", v), {31'b0, bo}, {31'b0, vecs[v].bout});
            chk($sformatf("vec%0d_latency", v), lat, 32'd4);
            chk($sformatf("vec%0d_busy_cycles", v), bcnt, 32'd4);
        end

        // Inputs changed after accept must not disturb the result
        run_op(4'b0110, 4'b0100, 1'b0, 1'b1, d, bo, lat, bcnt);
        chk("scramble_diff", {28'b0, d}, 32'h2);
        chk("scramble_bout", {31'b0, bo}, 32'd0);

        // start held through SHIFT and DONE is dropped
        @(negedge clk);
        A = 4'b0110; B = 4'b0100; Bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        A = 4'b1111; B = 4'b0000; Bin = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("drop_latency", lat, 32'd4);
        chk("drop_diff", {28'b0, Diff}, 32'h2);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_no_accept", {31'b0, busy}, 32'd0);

        // start held high: back-to-back operations every 6 cycles
        @(negedge clk);
        A = 4'b1110; B = 4'b0010; Bin = 1'b0; start = 1'b1;
        prev = -1; ndone = 0; stable_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (prev >= 0) chk("hold_interval", c - prev, 32'd6);
                chk("hold_diff", {28'b0, Diff}, 32'hC);
                prev = c;
                ndone++;
            end else if (ndone == 0 && Diff !== 4'b0010) begin
                stable_ok = 1'b0;
            end
        end
        start = 1'b0;
        chk("hold_done_count", ndone, 32'd6);
        chk("hold_diff_stable", {31'b0, stable_ok}, 32'd1);
        repeat (8) @(posedge clk);

        // Asynchronous reset during the second SHIFT cycle
        @(negedge clk);
        A = 4'b1010; B = 4'b0001; Bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_diff", {28'b0, Diff}, 32'd0);
        chk("midrst_bout", {31'b0, Bout}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        no_done = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) no_done = 1'b0;
        end
        chk("midrst_no_done", {31'b0, no_done}, 32'd1);
        run_op(4'b0011, 4'b0001, 1'b0, 1'b0, d, bo, lat, bcnt);
        chk("after_rst_diff", {28'b0, d}, 32'h2);
        chk("after_rst_bout", {31'b0, bo}, 32'd0);

        // Closed loop with a 4-bit adder model: (A+B+Cin) - B - Cin recovers A
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    full = 5'(a + b + ci);
                    run_op(full[3:0], 4'(b), 1'(ci), 1'b0, d, bo, lat, bcnt);
                    chk($sformatf("loop_a%0d_b%0d_c%0d_diff", a, b, ci), {28'b0, d}, 32'(a));
                    chk($sformatf("loop_a%0d_b%0d_c%0d_bout", a, b, ci), {31'b0, bo}, {31'b0, full[4]});
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor with borrow-in and a start/busy/done handshake. It computes Diff = A − B − Bin one bit per clock, LSB first, through a single 1-bit full-subtractor cell and a borrow flip-flop. It is the inverse-operation companion to the team's 4-bit ripple full adder. A bench can feed the adder's Sum back as A with the same B and Cin, and check that the original operand is recovered.

## Interface
- WIDTH, 4: operand and result width in bits (≥2).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request. Sampled only in IDLE.
- A  input  WIDTH  minuend. Captured on the accepted start edge.
- B  input  WIDTH  subtrahend. Captured on the accepted start edge.
- Bin  input  1  borrow-in. Captured on the accepted start edge.
- busy  output  1  high from the cycle after accept until the result is presented.
- done  output  1  one-cycle pulse: Diff/Bout are valid and newly updated.
- Diff  output  WIDTH  result, registered. Holds until the next completion.
- Bout  output  1  borrow-out, registered. 1 when A < B + Bin (unsigned).

## Operation
- States:
  - IDLE: waits for start.
  - SHIFT: processes bits.
  - DONE: presents the result.
- IDLE → SHIFT when start=1 at a rising edge:
  - Loads the a_sh and b_sh shift registers with A and B.
  - Loads the borrow flop with Bin.
  - Clears the bit counter.
- In each SHIFT cycle:
  - d = a_sh[0] ^ b_sh[0] ^ br
  - br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br)
  - d shifts into the MSB of the internal d_sh register.
  - a_sh and b_sh shift right by one.
  - The counter increments.
- SHIFT → DONE on the edge that processes bit WIDTH−1. On that same edge, Diff ← final d_sh and Bout ← br_next.
- DONE → IDLE unconditionally on the next edge.
- Result is modulo 2^WIDTH. Bout is the true borrow of the full WIDTH+1-bit subtraction.
- start is ignored in SHIFT and DONE. There is no queuing; the request is dropped.
- A, B and Bin may change freely after the accept edge without affecting the result.
- Diff and Bout change only on a completion edge, never during SHIFT.
- Reset (asynchronous, any state, including mid-operation):
  - State → IDLE.
  - busy=0, done=0, Diff=0, Bout=0.
  - Shift registers, borrow flop and counter are cleared.
  - The in-flight operation is abandoned and no done is produced.
- Counter width is $clog2(WIDTH). Its terminal value is WIDTH−1.

## Timing
- Let the accept edge be t0.
- busy=1 after t0, through t0+WIDTH.
- Each edge t1..tWIDTH processes one bit.
- At tWIDTH:
  - State → DONE.
  - busy → 0.
  - done → 1.
  - Diff/Bout update.
- At tWIDTH+1: done → 0 and state → IDLE.
- A new start is accepted at tWIDTH+2 at the earliest.
- Latency is WIDTH edges from accept to done. Throughput is one operation per WIDTH+2 cycles.
- All outputs are registered. There are no combinational input-to-output paths.

## Structure
- Shared package/include holds:
  - The state encodings: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - 2'd3 is illegal and recovers to IDLE.
- Sub-module fs1 is a purely combinational 1-bit full subtractor:
  - Inputs: a, b, bin.
  - Outputs: d, bout.
  - Instantiated once in the datapath.
- Top level holds the FSM, counter, shift registers, borrow flop and output registers.

## Test plan
- A=0110, B=0100, Bin=0, start pulse → done exactly 4 edges after accept. Diff=0010, Bout=0. busy high for 4 cycles.
- A=1000, B=1001, Bin=1 → Diff=1110, Bout=1. A=1110, B=0010, Bin=0 → Diff=1100, Bout=0. A=1010, B=1011, Bin=0 → Diff=1111, Bout=1.
- Inputs changed to A=1111, B=0000 one cycle after accepting A=0110, B=0100 → result is still Diff=0010.
- start held high continuously → operations complete every 6 cycles. start pulses during SHIFT/DONE are dropped. Diff is stable between done pulses.
- rst_n low at the second SHIFT cycle of A=1010, B=0001 → all outputs 0 immediately, no done pulse. The next operation with A=0011, B=0001 gives Diff=0010.
- Closed loop with the 4-bit adder: for all A, B, Cin, feed Sum as A and Cin as Bin → Diff equals the original A.
